equiv_sweep: RTL and testbench
==============================

# equiv_sweep

Parametrised sequential equivalence checker for lab designs. It sweeps every input vector of width N_IN through two externally instantiated implementations, the original and the simplified equivalent. It compares their outputs and counts mismatches. It also records the first failing vector and reports pass/fail. It replaces the purely combinational XOR miscompare flag at the lab top level and supports implementations pipelined by LAT cycles.

## Interface
- N_IN, 5, width of the stimulus vector; 2^N_IN vectors are swept (1..16)
- LAT, 0, pipeline latency in cycles from `vec` to `out_a`/`out_b` (0..7)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- start  in  1  one-cycle request to begin a sweep
- out_a  in  1  output of the original implementation
- out_b  in  1  output of the equivalent implementation
- vec  out  N_IN  stimulus driven to both implementations, registered
- busy  out  1  high while in SWEEP or DRAIN
- done  out  1  high in DONE; held until the next accepted start or reset
- pass  out  1  equals done AND (mismatch_cnt == 0)
- mismatch_cnt  out  N_IN+1  number of mismatching vectors
- first_fail  out  N_IN  first vector that mismatched; valid when fail_valid=1
- fail_valid  out  1  at least one mismatch has been recorded

## Operation
- States are IDLE, SWEEP, DRAIN and DONE. Reset puts the block in IDLE with every output at 0.
- IDLE or DONE, start=1: clear mismatch_cnt, first_fail and fail_valid; set vec=0; go to SWEEP.
- SWEEP: vec increments by 1 per cycle. When vec reaches all-ones it holds that value, and the state goes to DRAIN if LAT>0, else DONE.
- DRAIN: lasts LAT cycles so in-flight results can land, then goes to DONE.
- Tag pipeline:
  - A LAT-deep shift register carries (valid, vec) tags. With LAT=0 the tag is the current SWEEP vec.
  - When the tag is valid and out_a != out_b: mismatch_cnt increments. If fail_valid=0, first_fail takes the tag vector and fail_valid is set.
- Counter width N_IN+1 holds the maximum 2^N_IN without saturation logic.
- start while busy is ignored.
- vec stays frozen in DONE.
- Asynchronous reset at any point aborts the sweep. All outputs return to 0 and the pipeline tags are cleared.

## Timing
- start is sampled at edge k. From k+1: busy=1 and vec=0.
- vec takes values 0..2^N_IN-1 on cycles k+1..k+2^N_IN.
- The compare for a vector issued at cycle t happens at t+LAT. The count updates at the edge ending that cycle.
- DONE is entered at cycle k+2^N_IN+LAT+1. In the same cycle busy=0, and done, pass and counters are final.
- Sweep latency from start to done is 2^N_IN+LAT+1 cycles.
- pass and done are registered, with no combinational path from out_a/out_b.

## Configuration
- EQ_STOP_ON_FAIL_EN defined:
  - The first valid mismatch moves the FSM directly to DONE at the next edge.
  - mismatch_cnt=1, pass=0, and vec freezes at its current value.
  - Tags still in flight are discarded.
- EQ_STOP_ON_FAIL_EN undefined: the full sweep always runs and every mismatch is counted.

## Test plan
- N_IN=5, LAT=0, out_b=out_a (same function), start pulse -> done 33 cycles after start; pass=1, mismatch_cnt=0, fail_valid=0.
- N_IN=5, LAT=0, out_b = out_a ^ (vec==19) -> mismatch_cnt=1, first_fail=19, fail_valid=1, pass=0.
- N_IN=5, LAT=2, both implementations modelled with 2-cycle delay, out_b flips on vectors 3 and 30 -> done 35 cycles after start; mismatch_cnt=2, first_fail=3.
- rst asserted while vec=12 mid-sweep, then a new start -> all outputs 0 immediately; the new sweep starts at vec=0 and gives correct counts.
- start pulsed again while busy -> ignored; vec sequence is unbroken and done timing is unchanged.
- EQ_STOP_ON_FAIL_EN, mismatches on 7 and 9, LAT=0 -> done one cycle after vec=7 is compared; mismatch_cnt=1, first_fail=7, vec=7 held.

Source files
------------

// File: rtl/equiv_sweep_if.sv
// Stimulus/result bundle between equiv_sweep (slave) and the lab harness that
// owns the two implementations under comparison (master).
interface equiv_sweep_if #(
    parameter int N_IN = 5
);
    logic            start;
    logic            out_a;
    logic            out_b;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   mismatch_cnt;
    logic [N_IN-1:0] first_fail;
    logic            fail_valid;

    modport master (
        output start, out_a, out_b,
        input  vec, busy, done, pass, mismatch_cnt, first_fail, fail_valid
    );

    modport slave (
        input  start, out_a, out_b,
        output vec, busy, done, pass, mismatch_cnt, first_fail, fail_valid
    );
endinterface

// File: rtl/equiv_sweep.sv
// Exhaustive sequential equivalence sweep of two LAT-pipelined implementations.
// Optional EQ_STOP_ON_FAIL_EN: end the sweep at the first valid mismatch.
module equiv_sweep #(
    parameter int N_IN = 5,
    parameter int LAT  = 0
) (
    input logic         clk,
    input logic         rst,
    equiv_sweep_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [N_IN-1:0] ALL_ONES   = '1;
    localparam logic [2:0]      DRAIN_LAST = 3'(LAT > 0 ? LAT - 1 : 0);

    logic [1:0]      state, state_n;
    logic [N_IN-1:0] vec, vec_n;
    logic [N_IN:0]   cnt, cnt_n;
    logic [N_IN-1:0] first_fail, ff_n;
    logic            fail_valid, fv_n;
    logic [2:0]      drain_cnt, drain_n;
    logic            busy, done, pass;

    logic            cmp_valid;
    logic [N_IN-1:0] cmp_vec;
    logic            miscompare;

    // Tag of the vector whose results are on out_a/out_b this cycle.
    generate
        if (LAT == 0) begin : g_direct
            assign cmp_valid = (state == S_SWEEP);
            assign cmp_vec   = vec;
        end else begin : g_tags
            logic [LAT-1:0]  tag_v;
            logic [N_IN-1:0] tag_vec [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_v <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        tag_vec[i] <= '0;
                    end
                end else if (state_n == S_DONE || state_n == S_IDLE) begin
                    tag_v <= '0;
                end else begin
                    tag_v[0]   <= (state == S_SWEEP);
                    tag_vec[0] <= vec;
                    for (int i = 1; i < LAT; i++) begin
                        tag_v[i]   <= tag_v[i-1];
                        tag_vec[i] <= tag_vec[i-1];
                    end
                end
            end

            assign cmp_valid = tag_v[LAT-1] && busy;
            assign cmp_vec   = tag_vec[LAT-1];
        end
    endgenerate

    assign miscompare = cmp_valid && (bus.out_a != bus.out_b);

    always_comb begin
        state_n = state;
        vec_n   = vec;
        cnt_n   = cnt;
        ff_n    = first_fail;
        fv_n    = fail_valid;
        drain_n = drain_cnt;

        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_n = S_SWEEP;
                    vec_n   = '0;
                    cnt_n   = '0;
                    ff_n    = '0;
                    fv_n    = 1'b0;
                end
            end
            S_SWEEP: begin
                if (vec == ALL_ONES) begin
                    drain_n = '0;
                    state_n = (LAT > 0) ? S_DRAIN : S_DONE;
                end else begin
                    vec_n = vec + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_n = S_DONE;
                end else begin
                    drain_n = drain_cnt + 3'd1;
                end
            end
            default: ;
        endcase

        // miscompare is only possible while busy, so it never collides with a start.
        if (miscompare) begin
            cnt_n = cnt + 1'b1;
            if (!fail_valid) begin
                ff_n = cmp_vec;
                fv_n = 1'b1;
            end
`ifdef EQ_STOP_ON_FAIL_EN
            state_n = S_DONE;
            vec_n   = vec;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            vec        <= '0;
            cnt        <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            state      <= state_n;
            vec        <= vec_n;
            cnt        <= cnt_n;
            first_fail <= ff_n;
            fail_valid <= fv_n;
            drain_cnt  <= drain_n;
            busy       <= (state_n == S_SWEEP) || (state_n == S_DRAIN);
            done       <= (state_n == S_DONE);
            pass       <= (state_n == S_DONE) && (cnt_n == '0);
        end
    end

    assign bus.vec          = vec;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.pass         = pass;
    assign bus.mismatch_cnt = cnt;
    assign bus.first_fail   = first_fail;
    assign bus.fail_valid   = fail_valid;
endmodule

// File: tb/tb_equiv_sweep.sv
// Self-checking bench for equiv_sweep: one LAT=0 and one LAT=2 instance, each
// fed by truth-table implementations whose outputs differ on a chosen vector set.
module tb_equiv_sweep;
    localparam int N  = 5;
    localparam int NV = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    equiv_sweep_if #(.N_IN(N)) bus0 ();
    equiv_sweep_if #(.N_IN(N)) bus1 ();

    equiv_sweep #(.N_IN(N), .LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    equiv_sweep #(.N_IN(N), .LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus1));

    // Implementations: out_a is a truth table, out_b flips it on the masked vectors.
    logic        start_s [2];
    logic [31:0] tbl_s   [2];
    logic [31:0] msk_s   [2];
    logic [N-1:0] d1 = '0;
    logic [N-1:0] d2 = '0;

    always @(posedge clk) begin
        d1 <= bus1.vec;
        d2 <= d1;
    end

    assign bus0.start = start_s[0];
    assign bus0.out_a = tbl_s[0][bus0.vec];
    assign bus0.out_b = tbl_s[0][bus0.vec] ^ msk_s[0][bus0.vec];
    assign bus1.start = start_s[1];
    assign bus1.out_a = tbl_s[1][d2];
    assign bus1.out_b = tbl_s[1][d2] ^ msk_s[1][d2];

    logic [N-1:0] vec_s  [2];
    logic         busy_s [2];
    logic         done_s [2];
    logic         pass_s [2];
    logic [N:0]   cnt_s  [2];
    logic [N-1:0] ff_s   [2];
    logic         fv_s   [2];

    assign vec_s[0]  = bus0.vec;          assign vec_s[1]  = bus1.vec;
    assign busy_s[0] = bus0.busy;         assign busy_s[1] = bus1.busy;
    assign done_s[0] = bus0.done;         assign done_s[1] = bus1.done;
    assign pass_s[0] = bus0.pass;         assign pass_s[1] = bus1.pass;
    assign cnt_s[0]  = bus0.mismatch_cnt; assign cnt_s[1]  = bus1.mismatch_cnt;
    assign ff_s[0]   = bus0.first_fail;   assign ff_s[1]   = bus1.first_fail;
    assign fv_s[0]   = bus0.fail_valid;   assign fv_s[1]   = bus1.fail_valid;

    typedef struct {
        int          sel;
        logic [31:0] mask;
        logic [31:0] tbl;
        int          restart;
        bit          pre_reset;
        int          exp_cnt;
        int          exp_first;
        int          exp_fv;
        int          exp_pass;
        int          exp_lat;
        int          exp_vec;
    } vec_t;

    vec_t vt [NV];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Reference: the result of a sweep follows from the mismatch set alone.
    function automatic vec_t model(input int sel, input logic [31:0] mask, input logic [31:0] tbl,
                                   input int restart, input bit pre_reset);
        vec_t r;
        int lat   = (sel == 1) ? 2 : 0;
        int pop   = 0;
        int first = -1;
        for (int v = 0; v < 32; v++) begin
            if (mask[v]) begin
                pop++;
                if (first < 0) first = v;
            end
        end
        r.sel = sel; r.mask = mask; r.tbl = tbl; r.restart = restart; r.pre_reset = pre_reset;
        r.exp_first = (first < 0) ? 0 : first;
        r.exp_fv    = (first < 0) ? 0 : 1;
        r.exp_pass  = (first < 0) ? 1 : 0;
        r.exp_cnt   = pop;
        r.exp_lat   = 32 + lat + 1;
        r.exp_vec   = 31;
`ifdef EQ_STOP_ON_FAIL_EN
        if (first >= 0) begin
            r.exp_cnt = 1;
            r.exp_lat = first + lat + 2;
            r.exp_vec = (first + lat > 31) ? 31 : first + lat;
        end
`endif
        return r;
    endfunction

    function automatic vec_t lit(input int sel, input logic [31:0] mask, input logic [31:0] tbl,
                                 input int restart, input int cnt, input int first, input int fv,
                                 input int pass, input int lat, input int vecf);
        vec_t r;
        r.sel = sel; r.mask = mask; r.tbl = tbl; r.restart = restart; r.pre_reset = 1'b0;
        r.exp_cnt = cnt; r.exp_first = first; r.exp_fv = fv; r.exp_pass = pass;
        r.exp_lat = lat; r.exp_vec = vecf;
        return r;
    endfunction

    task automatic fillTable();
        logic [31:0] m;
        vt[0] = lit(0, 32'h0, 32'h6F3A_91C4, -1, 0, 0, 0, 1, 33, 31);
        vt[5] = lit(0, 32'h0, 32'h5555_AAAA, 10, 0, 0, 0, 1, 33, 31);
`ifdef EQ_STOP_ON_FAIL_EN
        vt[1] = lit(0, 32'h1 << 19, 32'h1234_ABCD, -1, 1, 19, 1, 0, 21, 19);
        vt[2] = lit(1, (32'h1 << 3) | (32'h1 << 30), 32'hC0DE_5A5A, -1, 1, 3, 1, 0, 7, 5);
        vt[3] = lit(0, (32'h1 << 7) | (32'h1 << 9), 32'h0F0F_3C3C, -1, 1, 7, 1, 0, 9, 7);
        vt[4] = lit(1, 32'h8000_0001, 32'hA5A5_0FF0, 3, 1, 0, 1, 0, 4, 2);
`else
        vt[1] = lit(0, 32'h1 << 19, 32'h1234_ABCD, -1, 1, 19, 1, 0, 33, 31);
        vt[2] = lit(1, (32'h1 << 3) | (32'h1 << 30), 32'hC0DE_5A5A, -1, 2, 3, 1, 0, 35, 31);
        vt[3] = lit(0, (32'h1 << 7) | (32'h1 << 9), 32'h0F0F_3C3C, -1, 2, 7, 1, 0, 33, 31);
        vt[4] = lit(1, 32'h8000_0001, 32'hA5A5_0FF0, 3, 2, 0, 1, 0, 35, 31);
`endif
        vt[6] = model(1, (32'h1 << 5) | (32'h1 << 20), 32'h3C3C_F00F, -1, 1'b1);
        for (int i = 7; i < NV; i++) begin
            m = '0;
            for (int b = 0; b < 32; b++) m[b] = ($urandom_range(0, 7) == 0);
            vt[i] = model(int'($urandom_range(0, 1)), m, $urandom, int'($urandom_range(0, 40)) - 10, 1'b0);
        end
    endtask

    task automatic checkIdle(input int s, input string pfx);
        checkOutput({pfx, "_vec"},  int'(vec_s[s]),  0);
        checkOutput({pfx, "_busy"}, int'(busy_s[s]), 0);
        checkOutput({pfx, "_done"}, int'(done_s[s]), 0);
        checkOutput({pfx, "_pass"}, int'(pass_s[s]), 0);
        checkOutput({pfx, "_cnt"},  int'(cnt_s[s]),  0);
        checkOutput({pfx, "_ff"},   int'(ff_s[s]),   0);
        checkOutput({pfx, "_fv"},   int'(fv_s[s]),   0);
    endtask

    // Abort a sweep with an asynchronous reset once it is mid-way (vec == 12).
    task automatic abortSweep(input int s);
        int n = 0;
        @(negedge clk); start_s[s] = 1'b1;
        @(posedge clk); #1 start_s[s] = 1'b0;
        while (vec_s[s] != 5'd12 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("abort_reach_vec12", int'(vec_s[s]), 12);
        #2 rst = 1'b1;
        #1 checkIdle(s, "abort");
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic applyStimulus(input int idx);
        vec_t t = vt[idx];
        int   s = t.sel;
        int   cyc;
        int   bad = 0;
        int   expv;
        tbl_s[s] = t.tbl;
        msk_s[s] = t.mask;
        if (t.pre_reset) abortSweep(s);
        @(negedge clk); start_s[s] = 1'b1;
        @(posedge clk); #1 start_s[s] = 1'b0;
        cyc = 1;
        checkOutput($sformatf("v%0d_busy_after_start", idx), int'(busy_s[s]), 1);
        checkOutput($sformatf("v%0d_vec_after_start", idx), int'(vec_s[s]), 0);
        while (!done_s[s] && cyc < 200) begin
            expv = (cyc - 1 > 31) ? 31 : cyc - 1;
            if (busy_s[s] && int'(vec_s[s]) != expv) bad++;
            if (cyc == t.restart && busy_s[s]) start_s[s] = 1'b1;
            @(posedge clk); #1;
            start_s[s] = 1'b0;
            cyc++;
        end
        checkOutput($sformatf("v%0d_vec_sequence_errors", idx), bad, 0);
        checkOutput($sformatf("v%0d_latency", idx), cyc, t.exp_lat);
        checkOutput($sformatf("v%0d_busy_at_done", idx), int'(busy_s[s]), 0);
        checkOutput($sformatf("v%0d_mismatch_cnt", idx), int'(cnt_s[s]), t.exp_cnt);
        checkOutput($sformatf("v%0d_fail_valid", idx), int'(fv_s[s]), t.exp_fv);
        if (t.exp_fv != 0)
            checkOutput($sformatf("v%0d_first_fail", idx), int'(ff_s[s]), t.exp_first);
        checkOutput($sformatf("v%0d_pass", idx), int'(pass_s[s]), t.exp_pass);
        checkOutput($sformatf("v%0d_vec_final", idx), int'(vec_s[s]), t.exp_vec);
        repeat (3) @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_vec_frozen", idx), int'(vec_s[s]), t.exp_vec);
        checkOutput($sformatf("v%0d_done_held", idx), int'(done_s[s]), 1);
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start_s[s] = 1'b0;
            tbl_s[s]   = '0;
            msk_s[s]   = '0;
        end
        #1;
        checkIdle(0, "reset0");
        checkIdle(1, "reset2");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fillTable();
        for (int i = 0; i < NV; i++) begin
            $display("[TB] vector %0d: dut_lat=%0d mask=%h restart=%0d", i,
                     (vt[i].sel == 1) ? 2 : 0, vt[i].mask, vt[i].restart);
            applyStimulus(i);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
